// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic                  if_gnt;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ls_req;
  logic                  ls_gnt;
  logic [ADDR_W-1:0]     ls_addr;
  logic                  ls_we;
  logic [DATA_W/8-1:0]   ls_be;
  logic [DATA_W-1:0]     ls_wdata;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_req;
  logic                  mem_gnt;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  // master: the arbiter itself; slave: the core wrapper and memory around it
  modport master (
    input  if_req, if_addr,
    input  ls_req, ls_addr, ls_we, ls_be, ls_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );

  modport slave (
    output if_req, if_addr,
    output ls_req, ls_addr, ls_we, ls_be, ls_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/LS arbiter onto one memory port with in-order response routing
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               err
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BE_W  = DATA_W / 8;

  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       rr_prio_q, rr_prio_d;
  logic                       lock_q, lock_d;
  logic                       lock_id_q, lock_id_d;
  logic                       err_q, err_d;

  logic              full;
  logic              lock_hold;
  logic              sel;
  logic              sel_req;
  logic              req_out;
  logic              accept;
  logic              pop;
  logic              head;
  logic [ADDR_W-1:0] addr_mux;
  logic              we_mux;
  logic [BE_W-1:0]   be_mux;
  logic [DATA_W-1:0] wdata_mux;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Selection: lock wins while the locked requester still asserts req, then rr_prio on contention.
  always_comb begin
    full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    lock_hold = lock_q && (lock_id_q ? bus.ls_req : bus.if_req);
    if (lock_hold) begin
      sel = lock_id_q;
    end else if (bus.if_req && bus.ls_req) begin
      sel = rr_prio_q;
    end else begin
      sel = bus.ls_req;
    end
    sel_req = sel ? bus.ls_req : bus.if_req;
    req_out = !rst && !full && sel_req;
    accept  = req_out && bus.mem_gnt;
    head    = fifo_q[rptr_q];
    pop     = !rst && bus.mem_rvalid && (count_q != '0);
  end

  always_comb begin
    addr_mux  = bus.if_addr;
    we_mux    = 1'b0;
    be_mux    = '1;
    wdata_mux = '0;
    if (sel) begin
      addr_mux  = bus.ls_addr;
      we_mux    = bus.ls_we;
      be_mux    = bus.ls_be;
      wdata_mux = bus.ls_wdata;
    end
  end

  // A pop never frees a slot for a same-cycle push: req_out looks only at count_q.
  always_comb begin
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rr_prio_d = rr_prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q;
    if (accept) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = ptr_inc(wptr_q);
      rr_prio_d      = ~sel;
      lock_d         = 1'b0;
    end else if (req_out) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, accept} - {{(CNT_W-1){1'b0}}, pop};
    if (bus.mem_rvalid && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rr_prio_q <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rr_prio_q <= rr_prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_req   = req_out;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_we    = we_mux;
  assign bus.mem_be    = be_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.if_gnt    = accept && !sel;
  assign bus.ls_gnt    = accept && sel;
  assign bus.if_rvalid = pop && !head;
  assign bus.ls_rvalid = pop && head;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;
  assign err           = err_q && !rst;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a queue model
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXO   = 2;

  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: outstanding owners in issue order, priority owner, pending lock.
  int q[$];
  int m_rr;
  bit m_lock;
  int m_lock_id;
  bit m_err;
  int m_granted;

  logic        obs_if_gnt, obs_ls_gnt, obs_mem_req, obs_if_rvalid, obs_ls_rvalid, obs_err;
  logic [31:0] obs_addr, obs_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_we      = 1'b0;
    bus.ls_be      = '0;
    bus.ls_wdata   = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic step();
    int owner;
    bit e_acc, e_pop;
    int head;
    logic [31:0] e_addr;
    owner = -1;
    if (!rst && q.size() < MAXO) begin
      if (m_lock && ((m_lock_id == 1) ? bus.ls_req : bus.if_req)) owner = m_lock_id;
      else if (bus.if_req && bus.ls_req) owner = m_rr;
      else if (bus.if_req) owner = 0;
      else if (bus.ls_req) owner = 1;
    end
    e_acc = (owner >= 0) && bus.mem_gnt;
    e_pop = !rst && bus.mem_rvalid && (q.size() > 0);
    head  = e_pop ? q[0] : -1;
    e_addr = (owner == 1) ? bus.ls_addr : bus.if_addr;
    @(negedge clk);
    obs_if_gnt = bus.if_gnt;  obs_ls_gnt = bus.ls_gnt;  obs_mem_req = bus.mem_req;
    obs_if_rvalid = bus.if_rvalid;  obs_ls_rvalid = bus.ls_rvalid;
    obs_err = err;  obs_addr = bus.mem_addr;  obs_rdata = bus.if_rdata;
    chk("mem_req", bus.mem_req, owner >= 0);
    chk("if_gnt", bus.if_gnt, e_acc && owner == 0);
    chk("ls_gnt", bus.ls_gnt, e_acc && owner == 1);
    if (owner >= 0) begin
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_we", bus.mem_we, (owner == 1) ? bus.ls_we : 1'b0);
      chk("mem_be", bus.mem_be, (owner == 1) ? bus.ls_be : 4'hF);
      chk("mem_wdata", bus.mem_wdata, (owner == 1) ? bus.ls_wdata : 32'h0);
    end
    chk("if_rvalid", bus.if_rvalid, head == 0);
    chk("ls_rvalid", bus.ls_rvalid, head == 1);
    if (e_pop) begin
      chk("if_rdata", bus.if_rdata, bus.mem_rdata);
      chk("ls_rdata", bus.ls_rdata, bus.mem_rdata);
    end
    chk("err", err, !rst && m_err);
    @(posedge clk);
    m_granted = e_acc ? owner : -1;
    if (rst) begin
      q.delete();
      m_rr = 0;  m_lock = 1'b0;  m_lock_id = 0;  m_err = 1'b0;
    end else begin
      if (bus.mem_rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1'b1;
      end
      if (e_acc) begin
        q.push_back(owner);
        m_rr = 1 - owner;
        m_lock = 1'b0;
      end else if (owner >= 0) begin
        m_lock = 1'b1;
        m_lock_id = owner;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    bus.mem_rvalid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mem_rdata = $urandom;
      step();
    end
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    bit if_pend, ls_pend;
    idle();
    m_rr = 0;  m_lock = 1'b0;  m_lock_id = 0;  m_err = 1'b0;  m_granted = -1;
    rst = 1'b1;
    #1;
    step();
    step();
    chk("rst_mem_req", obs_mem_req, 1'b0);
    chk("rst_err", obs_err, 1'b0);
    rst = 1'b0;

    // single IF read
    bus.if_req = 1'b1;  bus.if_addr = 32'h1000_0000;  bus.mem_gnt = 1'b1;
    step();
    chk("single_if_gnt", obs_if_gnt, 1'b1);
    chk("single_addr", obs_addr, 32'h1000_0000);
    idle();
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 32'h0000_0013;
    step();
    chk("single_if_rvalid", obs_if_rvalid, 1'b1);
    chk("single_ls_rvalid", obs_ls_rvalid, 1'b0);
    chk("single_rdata", obs_rdata, 32'h0000_0013);

    // round-robin with immediate responses
    do_reset();
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0100;
    bus.ls_req = 1'b1;  bus.ls_addr = 32'h0000_0200;  bus.ls_we = 1'b1;
    bus.ls_be = 4'h3;   bus.ls_wdata = 32'hCAFE_F00D;  bus.mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = (i > 0);
      step();
      chk("rr_if_gnt", obs_if_gnt, (i % 2) == 0);
      chk("rr_ls_gnt", obs_ls_gnt, (i % 2) == 1);
    end
    drain(1);

    // address-phase lock under stall
    do_reset();
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_1234;
    bus.ls_req = 1'b1;  bus.ls_addr = 32'h0000_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_addr", obs_addr, 32'h0000_1234);
    end
    bus.mem_gnt = 1'b1;
    step();
    chk("lock_if_first", obs_if_gnt, 1'b1);
    bus.if_req = 1'b0;
    step();
    chk("lock_ls_next", obs_ls_gnt, 1'b1);
    drain(2);

    // lock on LS must override IF priority
    do_reset();
    bus.ls_req = 1'b1;  bus.ls_addr = 32'h0000_0ABC;
    step();
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0DEF;
    step();
    chk("lockls_addr", obs_addr, 32'h0000_0ABC);
    bus.mem_gnt = 1'b1;
    step();
    chk("lockls_gnt", obs_ls_gnt, 1'b1);
    bus.ls_req = 1'b0;
    step();
    chk("lockls_if_after", obs_if_gnt, 1'b1);
    drain(2);

    // full stalls, response frees a slot next cycle
    do_reset();
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0040;  bus.mem_gnt = 1'b1;
    step();
    bus.if_req = 1'b0;  bus.ls_req = 1'b1;  bus.ls_addr = 32'h0000_0080;
    step();
    bus.ls_req = 1'b0;  bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0044;
    step();
    chk("full_mem_req", obs_mem_req, 1'b0);
    chk("full_if_gnt", obs_if_gnt, 1'b0);
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 32'h1111_1111;
    step();
    chk("full_pop_no_req", obs_mem_req, 1'b0);
    chk("full_first_if", obs_if_rvalid, 1'b1);
    bus.mem_rvalid = 1'b0;
    step();
    chk("full_resume", obs_if_gnt, 1'b1);
    bus.if_req = 1'b0;  bus.mem_rvalid = 1'b1;  bus.mem_rdata = 32'h2222_2222;
    step();
    chk("full_second_ls", obs_ls_rvalid, 1'b1);
    step();
    chk("full_third_if", obs_if_rvalid, 1'b1);
    bus.mem_rvalid = 1'b0;

    // 10 interleaved transactions, 1-cycle response latency, pointer wrap
    do_reset();
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.if_req = (i % 2) == 0;  bus.if_addr = 32'h100 + i;
      bus.ls_req = (i % 2) == 1;  bus.ls_addr = 32'h200 + i;
      bus.ls_we = i[1];  bus.ls_be = 4'(i);  bus.ls_wdata = $urandom;
      bus.mem_rvalid = (i > 0);  bus.mem_rdata = $urandom;
      step();
      chk("wrap_req", obs_mem_req, 1'b1);
      if (i > 0) chk("wrap_route", obs_ls_rvalid, (i % 2) == 0);
    end
    drain(1);

    // randomized traffic with held requests
    do_reset();
    if_pend = 1'b0;
    ls_pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1'b1;
        bus.if_addr = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 1) == 1) begin
        ls_pend = 1'b1;
        bus.ls_addr = $urandom;  bus.ls_we = 1'($urandom);
        bus.ls_be = 4'($urandom);  bus.ls_wdata = $urandom;
      end
      bus.if_req = if_pend;
      bus.ls_req = ls_pend;
      bus.mem_gnt = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.mem_rdata = $urandom;
      step();
      if (m_granted == 0) if_pend = 1'b0;
      if (m_granted == 1) ls_pend = 1'b0;
    end
    drain(2);

    // protocol error, sticky until reset, reset discards outstanding
    do_reset();
    bus.mem_rvalid = 1'b1;  bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    chk("err_no_if_rvalid", obs_if_rvalid, 1'b0);
    chk("err_no_ls_rvalid", obs_ls_rvalid, 1'b0);
    bus.mem_rvalid = 1'b0;
    step();
    chk("err_set", obs_err, 1'b1);
    step();
    step();
    chk("err_sticky", obs_err, 1'b1);
    bus.if_req = 1'b1;  bus.ls_req = 1'b1;  bus.mem_gnt = 1'b1;
    step();
    step();
    idle();
    rst = 1'b1;
    step();
    chk("err_in_rst", obs_err, 1'b0);
    rst = 1'b0;
    step();
    chk("err_after_rst", obs_err, 1'b0);
    bus.mem_rvalid = 1'b1;
    step();
    chk("stale_no_rvalid", obs_if_rvalid | obs_ls_rvalid, 1'b0);
    bus.mem_rvalid = 1'b0;
    step();
    chk("stale_err", obs_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
